// File: rtl/kinase_valve_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kinase_seq_pkg
// Description : Shared types and constants for the kinase valve sequencer:
//               FSM state encoding, control-line widths and the peristaltic
//               pump phase tables with their direction-aware index helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package kinase_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PUMP   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    localparam int CTRL_A_W = 13;
    localparam int CTRL_S_W = 4;
    localparam int PUMP_A_W = 3;
    localparam int PUMP_B_W = 2;

    // Forward phase order; reverse operation walks the same tables backwards.
    localparam logic [PUMP_A_W-1:0] PUMP_A_SEQ [0:5] =
        '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    localparam logic [PUMP_B_W-1:0] PUMP_B_SEQ [0:1] =
        '{2'b10, 2'b01};

    function automatic logic [2:0] pump_a_idx(input logic [2:0] phase, input logic dir);
        return dir ? (3'd5 - phase) : phase;
    endfunction

    // pump_b steps once per three pump_a phases.
    function automatic logic pump_b_idx(input logic [2:0] phase, input logic dir);
        return (phase >= 3'd3) ^ dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kinase_pump_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : kinase_pump_phase_gen
// Description : Peristaltic pump phase generator. Divides the clock into
//               PHASE_DIV-long phases, walks the 6-phase pump_a and 2-phase
//               pump_b tables (optionally reversed) and flags the last clock
//               of every full pump cycle. Pattern outputs are registered.
// Ports       : clk, rst          - clock, async active-high reset
//               start_i           - load phase 0 and start running
//               stop_i            - stop and drive both pumps to zero
//               sel_i[1:0]        - bit0 enables pump_a, bit1 enables pump_b
//               dir_i             - 1 runs both tables in reverse order
//               pump_a_o/pump_b_o - registered pump patterns
//               cyc_done_o        - high on the final clock of a pump cycle
// Revision    : 1.0 - initial release
// ============================================================================
module kinase_pump_phase_gen
    import kinase_seq_pkg::*;
#(
    parameter int PHASE_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [1:0]          sel_i,
    input  logic                dir_i,
    output logic [PUMP_A_W-1:0] pump_a_o,
    output logic [PUMP_B_W-1:0] pump_b_o,
    output logic                cyc_done_o
);

    localparam int              DIV_W    = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);

    logic                run_q;
    logic [DIV_W-1:0]    div_q;
    logic [2:0]          phase_q;
    logic [PUMP_A_W-1:0] pump_a_q;
    logic [PUMP_B_W-1:0] pump_b_q;

    logic                phase_end;
    logic [2:0]          phase_nxt;

    assign phase_end  = run_q && (div_q == DIV_LAST);
    assign phase_nxt  = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
    assign cyc_done_o = phase_end && (phase_q == 3'd5);
    assign pump_a_o   = pump_a_q;
    assign pump_b_o   = pump_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            phase_q  <= 3'd0;
            pump_a_q <= '0;
            pump_b_q <= '0;
        end else if (stop_i) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            phase_q  <= 3'd0;
            pump_a_q <= '0;
            pump_b_q <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            div_q    <= '0;
            phase_q  <= 3'd0;
            pump_a_q <= sel_i[0] ? PUMP_A_SEQ[pump_a_idx(3'd0, dir_i)] : '0;
            pump_b_q <= sel_i[1] ? PUMP_B_SEQ[pump_b_idx(3'd0, dir_i)] : '0;
        end else if (run_q) begin
            if (phase_end) begin
                div_q    <= '0;
                phase_q  <= phase_nxt;
                // Pattern is registered together with the phase so they never skew.
                pump_a_q <= sel_i[0] ? PUMP_A_SEQ[pump_a_idx(phase_nxt, dir_i)] : '0;
                pump_b_q <= sel_i[1] ? PUMP_B_SEQ[pump_b_idx(phase_nxt, dir_i)] : '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/kinase_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kinase_valve_sequencer
// Description : Step sequencer for the shared kinase_activity pneumatic lines.
//               Accepts one step descriptor per handshake, applies the static
//               valve pattern, settles, runs the selected pumps, holds, then
//               vents every line the step raised on its flush output.
// Ports       : clk, rst               - clock, async active-high reset
//               step_valid_i/ready_o   - descriptor handshake
//               step_ctrl_a_i/ctrl_s_i - static valve patterns
//               step_pump_sel_i        - pump enables {pump_b, pump_a}
//               step_pump_cycles_i     - full pump cycles to run
//               step_hold_i            - hold clocks after pumping
//               step_pump_dir_i        - reverse pump order (optional)
//               abort_i                - jump straight to flush
//               busy_o, done_o         - status
//               ctrl_*_o, pump_*_o     - valve drives
//               flush_*_o              - flush drives
// Options     : KINASE_SEQ_PUMP_REVERSE_EN adds step_pump_dir_i.
// Revision    : 1.0 - initial release
// ============================================================================
module kinase_valve_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int PHASE_DIV     = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int FLUSH_CYCLES  = 6,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_valid_i,
    output logic                step_ready_o,
    input  logic [CTRL_A_W-1:0] step_ctrl_a_i,
    input  logic [CTRL_S_W-1:0] step_ctrl_s_i,
    input  logic [1:0]          step_pump_sel_i,
    input  logic [CNT_W-1:0]    step_pump_cycles_i,
    input  logic [CNT_W-1:0]    step_hold_i,
    input  logic                abort_i,
`ifdef KINASE_SEQ_PUMP_REVERSE_EN
    input  logic                step_pump_dir_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic [CTRL_A_W-1:0] ctrl_a_o,
    output logic [CTRL_S_W-1:0] ctrl_s_o,
    output logic [PUMP_A_W-1:0] pump_a_o,
    output logic [PUMP_B_W-1:0] pump_b_o,
    output logic [CTRL_A_W-1:0] flush_ctrl_a_o,
    output logic [CTRL_S_W-1:0] flush_ctrl_s_o,
    output logic [PUMP_A_W-1:0] flush_pump_a_o,
    output logic [PUMP_B_W-1:0] flush_pump_b_o
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Latched descriptor
    logic [CTRL_A_W-1:0] pat_a_q;
    logic [CTRL_S_W-1:0] pat_s_q;
    logic [1:0]          sel_q;
    logic [CNT_W-1:0]    cyc_q, hold_q;
    logic                dir_q, dir_in;

    // Registered outputs and sticky "raised during this step" masks
    logic [CTRL_A_W-1:0] ctrl_a_q, ctrl_a_d, fl_a_q, fl_a_d, stk_a_q, stk_a_d;
    logic [CTRL_S_W-1:0] ctrl_s_q, ctrl_s_d, fl_s_q, fl_s_d, stk_s_q, stk_s_d;
    logic [PUMP_A_W-1:0] fl_pa_q, fl_pa_d, stk_pa_q, stk_pa_d;
    logic [PUMP_B_W-1:0] fl_pb_q, fl_pb_d, stk_pb_q, stk_pb_d;
    logic                done_q, done_d, busy_q, busy_d;

    logic                accept, go_pump, cyc_done, pump_start, pump_stop;
    state_e              post_pump_state;
    logic [CNT_W-1:0]    post_pump_cnt;

`ifdef KINASE_SEQ_PUMP_REVERSE_EN
    assign dir_in = step_pump_dir_i;
`else
    assign dir_in = 1'b0;
`endif

    assign step_ready_o    = (state_q == ST_IDLE);
    assign accept          = step_valid_i && step_ready_o;
    assign go_pump         = (sel_q != 2'b00) && (cyc_q != '0);
    assign post_pump_state = (hold_q != '0) ? ST_HOLD : ST_FLUSH;
    assign post_pump_cnt   = (hold_q != '0) ? hold_q : CNT_W'(FLUSH_CYCLES);
    // Pumps start on the edge entering PUMP and clear on the edge leaving it,
    // so they drop in the same cycle the flush lines rise.
    assign pump_start      = (state_q != ST_PUMP) && (state_d == ST_PUMP);
    assign pump_stop       = (state_d != ST_PUMP);

    kinase_pump_phase_gen #(
        .PHASE_DIV (PHASE_DIV)
    ) u_phase_gen (
        .clk        (clk),
        .rst        (rst),
        .start_i    (pump_start),
        .stop_i     (pump_stop),
        .sel_i      (sel_q),
        .dir_i      (dir_q),
        .pump_a_o   (pump_a_o),
        .pump_b_o   (pump_b_o),
        .cyc_done_o (cyc_done)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pat_a_q  <= '0;
            pat_s_q  <= '0;
            sel_q    <= 2'b00;
            cyc_q    <= '0;
            hold_q   <= '0;
            dir_q    <= 1'b0;
            ctrl_a_q <= '0;
            ctrl_s_q <= '0;
            fl_a_q   <= '0;
            fl_s_q   <= '0;
            fl_pa_q  <= '0;
            fl_pb_q  <= '0;
            stk_a_q  <= '0;
            stk_s_q  <= '0;
            stk_pa_q <= '0;
            stk_pb_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (accept) begin
                pat_a_q <= step_ctrl_a_i;
                pat_s_q <= step_ctrl_s_i;
                sel_q   <= step_pump_sel_i;
                cyc_q   <= step_pump_cycles_i;
                hold_q  <= step_hold_i;
                dir_q   <= dir_in;
            end
            ctrl_a_q <= ctrl_a_d;
            ctrl_s_q <= ctrl_s_d;
            fl_a_q   <= fl_a_d;
            fl_s_q   <= fl_s_d;
            fl_pa_q  <= fl_pa_d;
            fl_pb_q  <= fl_pb_d;
            stk_a_q  <= stk_a_d;
            stk_s_q  <= stk_s_d;
            stk_pa_q <= stk_pa_d;
            stk_pb_q <= stk_pb_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic. Counters count down to 1 and never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end else if (cnt_q <= CNT_W'(1)) begin
                    if (go_pump) begin
                        state_d = ST_PUMP;
                        cnt_d   = cyc_q;
                    end else begin
                        state_d = post_pump_state;
                        cnt_d   = post_pump_cnt;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PUMP: begin
                if (abort_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end else if (cyc_done) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = post_pump_state;
                        cnt_d   = post_pump_cnt;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (abort_i || (cnt_q <= CNT_W'(1))) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                // cnt reaches 0 on the done cycle; the FSM leaves one cycle later
                // so step_ready rises only after done.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values
    always_comb begin
        ctrl_a_d = ctrl_a_q;
        ctrl_s_d = ctrl_s_q;
        fl_a_d   = fl_a_q;
        fl_s_d   = fl_s_q;
        fl_pa_d  = fl_pa_q;
        fl_pb_d  = fl_pb_q;
        done_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        stk_a_d  = stk_a_q  | ctrl_a_q;
        stk_s_d  = stk_s_q  | ctrl_s_q;
        stk_pa_d = stk_pa_q | pump_a_o;
        stk_pb_d = stk_pb_q | pump_b_o;

        if (accept) begin
            ctrl_a_d = step_ctrl_a_i;
            ctrl_s_d = step_ctrl_s_i;
            stk_a_d  = '0;
            stk_s_d  = '0;
            stk_pa_d = '0;
            stk_pb_d = '0;
        end

        if ((state_q != ST_FLUSH) && (state_d == ST_FLUSH)) begin
            ctrl_a_d = '0;
            ctrl_s_d = '0;
            fl_a_d   = stk_a_d;
            fl_s_d   = stk_s_d;
            fl_pa_d  = stk_pa_d;
            fl_pb_d  = stk_pb_d;
        end

        if ((state_q == ST_FLUSH) && (cnt_q == CNT_W'(1))) begin
            fl_a_d  = '0;
            fl_s_d  = '0;
            fl_pa_d = '0;
            fl_pb_d = '0;
            done_d  = 1'b1;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign ctrl_a_o       = ctrl_a_q;
    assign ctrl_s_o       = ctrl_s_q;
    assign flush_ctrl_a_o = fl_a_q;
    assign flush_ctrl_s_o = fl_s_q;
    assign flush_pump_a_o = fl_pa_q;
    assign flush_pump_b_o = fl_pb_q;

endmodule
`default_nettype wire

// File: tb/tb_kinase_valve_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_kinase_valve_sequencer
// Description : Directed self-checking bench for kinase_valve_sequencer.
//               Each step is compared cycle by cycle against a timeline
//               model (settle, pump, hold, flush, done). Define
//               KINASE_SEQ_PUMP_REVERSE_EN to add the reverse-pump step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kinase_valve_sequencer;

    localparam int PD = 8;
    localparam int SC = 4;
    localparam int FC = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          step_valid;
    logic          step_ready;
    logic [12:0]   step_ctrl_a;
    logic [3:0]    step_ctrl_s;
    logic [1:0]    step_pump_sel;
    logic [CW-1:0] step_pump_cycles;
    logic [CW-1:0] step_hold;
    logic          abort;
    logic          step_pump_dir;
    logic          busy, done;
    logic [12:0]   ctrl_a, flush_ctrl_a;
    logic [3:0]    ctrl_s, flush_ctrl_s;
    logic [2:0]    pump_a, flush_pump_a;
    logic [1:0]    pump_b, flush_pump_b;

    int n_vec = 0;
    int n_bad = 0;
    bit overlap_seen;

    always #5 clk = ~clk;

    kinase_valve_sequencer #(
        .PHASE_DIV     (PD),
        .SETTLE_CYCLES (SC),
        .FLUSH_CYCLES  (FC),
        .CNT_W         (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .step_valid_i       (step_valid),
        .step_ready_o       (step_ready),
        .step_ctrl_a_i      (step_ctrl_a),
        .step_ctrl_s_i      (step_ctrl_s),
        .step_pump_sel_i    (step_pump_sel),
        .step_pump_cycles_i (step_pump_cycles),
        .step_hold_i        (step_hold),
        .abort_i            (abort),
`ifdef KINASE_SEQ_PUMP_REVERSE_EN
        .step_pump_dir_i    (step_pump_dir),
`endif
        .busy_o             (busy),
        .done_o             (done),
        .ctrl_a_o           (ctrl_a),
        .ctrl_s_o           (ctrl_s),
        .pump_a_o           (pump_a),
        .pump_b_o           (pump_b),
        .flush_ctrl_a_o     (flush_ctrl_a),
        .flush_ctrl_s_o     (flush_ctrl_s),
        .flush_pump_a_o     (flush_pump_a),
        .flush_pump_b_o     (flush_pump_b)
    );

    // A valve and its flush line must never be high together.
    always @(negedge clk) begin
        if (!rst && (((ctrl_a & flush_ctrl_a) != 0) || ((ctrl_s & flush_ctrl_s) != 0) ||
                     ((pump_a & flush_pump_a) != 0) || ((pump_b & flush_pump_b) != 0)))
            overlap_seen = 1'b1;
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {busy, done, ready, ctrl_a, ctrl_s, pump_a, pump_b, flush_a, flush_s, flush_pa, flush_pb}
    function automatic logic [63:0] pack_obs();
        return {17'd0, busy, done, step_ready, ctrl_a, ctrl_s, pump_a, pump_b,
                flush_ctrl_a, flush_ctrl_s, flush_pump_a, flush_pump_b};
    endfunction

    function automatic logic [2:0] exp_pa(input int u, input bit dir);
        int ph;
        ph = (u / PD) % 6;
        if (!dir) begin
            case (ph)
                0: return 3'b100;
                1: return 3'b110;
                2: return 3'b010;
                3: return 3'b011;
                4: return 3'b001;
                default: return 3'b101;
            endcase
        end else begin
            case (ph)
                0: return 3'b101;
                1: return 3'b001;
                2: return 3'b011;
                3: return 3'b010;
                4: return 3'b110;
                default: return 3'b100;
            endcase
        end
    endfunction

    function automatic logic [1:0] exp_pb(input int u, input bit dir);
        bit second;
        second = ((u / PD) % 6) >= 3;
        if (!dir) return second ? 2'b01 : 2'b10;
        return second ? 2'b10 : 2'b01;
    endfunction

    // Apply one step (accept at t=0) and compare every cycle through done.
    task automatic run_step(input string name, input logic [12:0] a, input logic [3:0] s,
                            input logic [1:0] sel, input int cyc, input int hold,
                            input bit dir, input int abort_t, input bit keep_valid);
        int pl, hs, fs_nom, fs, pe, done_t;
        logic [2:0] e_pa, acc_pa;
        logic [1:0] e_pb, acc_pb;
        logic       in_fl;
        pl     = (sel != 2'b00 && cyc != 0) ? cyc * 6 * PD : 0;
        hs     = 1 + SC + pl;
        fs_nom = hs + hold;
        fs     = (abort_t >= 1 && abort_t < fs_nom) ? abort_t + 1 : fs_nom;
        pe     = (hs < fs) ? hs : fs;
        done_t = fs + FC;
        acc_pa = 3'b000;
        acc_pb = 2'b00;
        @(negedge clk);
        step_valid       = 1'b1;
        step_ctrl_a      = a;
        step_ctrl_s      = s;
        step_pump_sel    = sel;
        step_pump_cycles = CW'(cyc);
        step_hold        = CW'(hold);
        step_pump_dir    = dir;
        abort            = (abort_t == 0);
        check_vec($sformatf("%s t=0", name), pack_obs(), {17'd0, 3'b001, 44'd0});
        for (int t = 1; t <= done_t; t++) begin
            @(negedge clk);
            step_valid = keep_valid;
            abort      = (t == abort_t);
            e_pa = (t >= 1 + SC && t < pe && sel[0]) ? exp_pa(t - 1 - SC, dir) : 3'b000;
            e_pb = (t >= 1 + SC && t < pe && sel[1]) ? exp_pb(t - 1 - SC, dir) : 2'b00;
            acc_pa = acc_pa | e_pa;
            acc_pb = acc_pb | e_pb;
            in_fl  = (t >= fs) && (t < fs + FC);
            check_vec($sformatf("%s t=%0d", name, t), pack_obs(),
                      {17'd0, 1'b1, (t == done_t), 1'b0,
                       (t < fs) ? a : 13'd0, (t < fs) ? s : 4'd0, e_pa, e_pb,
                       in_fl ? a : 13'd0, in_fl ? s : 4'd0,
                       in_fl ? acc_pa : 3'd0, in_fl ? acc_pb : 2'd0});
        end
        abort = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        step_valid       = 1'b0;
        step_ctrl_a      = '0;
        step_ctrl_s      = '0;
        step_pump_sel    = '0;
        step_pump_cycles = '0;
        step_hold        = '0;
        abort            = 1'b0;
        step_pump_dir    = 1'b0;

        repeat (3) @(negedge clk);
        // step_ready during reset is not defined; mask it out
        check_vec("reset", pack_obs() & ~(64'd1 << 44), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_vec("post-reset idle", pack_obs(), {17'd0, 3'b001, 44'd0});

        run_step("stepA",      13'h1001, 4'h3, 2'b01, 2, 5,  1'b0, -1, 1'b0);
        run_step("stepB",      13'h0AAA, 4'h5, 2'b11, 1, 3,  1'b0, -1, 1'b0);
        run_step("abortPump",  13'h1234, 4'hC, 2'b10, 3, 4,  1'b0,  8, 1'b0);
        run_step("abortSettl", 13'h00F0, 4'h1, 2'b01, 1, 0,  1'b0,  2, 1'b0);
        run_step("abortHold",  13'h0003, 4'h8, 2'b00, 0, 10, 1'b0,  7, 1'b0);
        run_step("abortFlush", 13'h1F00, 4'hF, 2'b00, 0, 0,  1'b0,  7, 1'b0);
        run_step("abortIdle",  13'h0421, 4'h2, 2'b11, 1, 0,  1'b0,  0, 1'b0);
        run_step("noCycles",   13'h0800, 4'h0, 2'b01, 0, 2,  1'b0, -1, 1'b0);
        run_step("b2b1",       13'h0101, 4'h2, 2'b00, 0, 0,  1'b0, -1, 1'b1);
        run_step("b2b2",       13'h0101, 4'h2, 2'b00, 0, 0,  1'b0, -1, 1'b1);
        run_step("b2b3",       13'h0101, 4'h2, 2'b00, 0, 0,  1'b0, -1, 1'b0);
`ifdef KINASE_SEQ_PUMP_REVERSE_EN
        run_step("reverse",    13'h0010, 4'h4, 2'b11, 1, 1,  1'b1, -1, 1'b0);
`endif

        // Asynchronous reset in the middle of a pump run
        @(negedge clk);
        step_valid       = 1'b1;
        step_ctrl_a      = 13'h1FFF;
        step_ctrl_s      = 4'hF;
        step_pump_sel    = 2'b11;
        step_pump_cycles = CW'(5);
        step_hold        = CW'(2);
        step_pump_dir    = 1'b0;
        @(negedge clk);
        step_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_vec("pre-reset pumps", {59'd0, pump_a, pump_b}, {59'd0, 3'b100, 2'b10});
        #2 rst = 1'b1;
        #1 check_vec("async reset", pack_obs() & ~(64'd1 << 44), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_vec("ready after reset", pack_obs(), {17'd0, 3'b001, 44'd0});

        check_vec("valve/flush overlap", {63'd0, overlap_seen}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
